frame_rx_ctrl: RTL



---
 rtl/frame_pkg.sv | 42 ++++
 rtl/crc16_ccitt_step.sv | 26 ++
 rtl/frame_rx_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_pkg : shared constants, state enums and descriptor layout
// Rev 1.0
// ------------------------------------------------------------------
package frame_pkg;

  localparam logic [15:0] HEADER_W    = 16'hE0E0;
  localparam logic [15:0] TRAILER_W   = 16'h0E0E;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam int unsigned MAX_WORDS   = 8;
  localparam int unsigned TIMEOUT_CYC = 64;

  // Each bank holds payload, CRC word and the trailer-high word.
  localparam int unsigned BANK_DEPTH  = MAX_WORDS + 2;
  localparam int unsigned CNT_W       = $clog2(BANK_DEPTH + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR2 = 2'd1,
    CHAN = 2'd2,
    DATA = 2'd3
  } parser_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_DESC = 2'd1,
    D_DATA = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [2:0] len;
    logic [7:0] ch;
  } desc_t;

  function automatic logic is_chan_word(input logic [15:0] w);
    return (w[15:8] == 8'h00) && $onehot(w[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_ccitt_step.sv
`default_nettype none
// ------------------------------------------------------------------
// crc16_ccitt_step : one 16-bit word CRC16-CCITT update, MSB first
// Rev 1.0
// ------------------------------------------------------------------
module crc16_ccitt_step
  import frame_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (crc_out[15] ^ data[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_rx_ctrl : frame hunt, CRC check, ping-pong staging, FIFO drain
// FRAME_TIMEOUT_EN adds the stalled-frame watchdog.   Rev 1.0
// ------------------------------------------------------------------
module frame_rx_ctrl
  import frame_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wdata,
  output logic        crc_valid,
  output logic        crc_err,
  output logic        frame_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BANK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_TRL = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_CRC = CNT_W'(2);

  parser_state_t    r_pstate;
  drain_state_t     r_dstate;
  logic [15:0]      r_bank [2][BANK_DEPTH];
  logic [1:0]       r_busy;
  logic [1:0]       r_ready;
  logic             r_older;
  logic [2:0]       r_blen [2];
  logic [7:0]       r_bch  [2];
  logic             r_pbank;
  logic [7:0]       r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_d1;
  logic [15:0]      r_d2;
  logic [15:0]      r_crc;
  logic             r_dbank;
  logic [CNT_W-1:0] r_didx;
  logic             r_ov;
  logic [15:0]      r_od;

  logic [15:0]      w_crc_next;
  logic [1:0]       w_free;
  logic [1:0]       w_drain_rel;
  logic             w_any_free;
  logic             w_claim_bank;
  logic             w_trailer;
  logic             w_overflow;
  logic             w_store;
  logic             w_adv;
  logic             w_pick;
  logic             w_pick_go;
  logic             w_last;
  desc_t            w_desc;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_timeout;
  assign w_timeout = (r_tmo == TMO_W'(TIMEOUT_CYC));
`endif

  // CRC lags two words behind storage so it never absorbs CRC or trailer words.
  crc16_ccitt_step u_crc (
    .crc_in  (r_crc),
    .data    (r_d2),
    .crc_out (w_crc_next)
  );

  assign w_free       = ~r_busy | w_drain_rel;
  assign w_any_free   = |w_free;
  assign w_claim_bank = ~w_free[0];
  assign w_trailer    = (r_cnt >= CNT_TRL) && (r_d1 == TRAILER_W) && (data_in == TRAILER_W);
  assign w_overflow   = (r_cnt == CNT_MAX);
  assign w_store      = (r_pstate == DATA) && !w_trailer && !w_overflow;

  assign w_adv     = !r_ov || !fifo_full;
  assign w_pick    = (r_ready == 2'b11) ? r_older : r_ready[1];
  assign w_pick_go = (r_dstate == D_IDLE) && (|r_ready);
  assign w_last    = (r_didx == CNT_W'(r_blen[r_dbank]));

  always_comb begin
    w_drain_rel = '0;
    if (r_dstate == D_DATA && w_adv && w_last) w_drain_rel[r_dbank] = 1'b1;
  end

  always_comb begin
    w_desc      = '0;
    w_desc.len  = r_blen[r_dbank];
    w_desc.ch   = r_bch[r_dbank];
  end

  always_ff @(posedge clk_in) begin
    if (w_store) r_bank[r_pbank][r_cnt] <= data_in;
  end

  // Parser FSM plus bank ownership; drain release is applied before any claim.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate   <= HUNT;
      r_busy     <= '0;
      r_ready    <= '0;
      r_older    <= 1'b0;
      r_pbank    <= 1'b0;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_crc      <= '0;
      crc_valid  <= 1'b0;
      crc_err    <= 1'b0;
      frame_drop <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_blen[b] <= '0;
        r_bch[b]  <= '0;
      end
`ifdef FRAME_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      crc_valid  <= 1'b0;
      crc_err    <= 1'b0;
      frame_drop <= 1'b0;
      r_busy     <= r_busy & ~w_drain_rel;
      if (w_pick_go) begin
        r_ready[w_pick] <= 1'b0;
        r_older         <= ~w_pick;
      end
`ifdef FRAME_TIMEOUT_EN
      r_tmo <= '0;
      if (r_pstate != HUNT && w_timeout) begin
        frame_drop <= 1'b1;
        if (r_pstate == DATA) r_busy[r_pbank] <= 1'b0;
        r_pstate <= HUNT;
      end else
`endif
      case (r_pstate)
        HUNT: if (data_in == HEADER_W) r_pstate <= HDR2;
        HDR2: r_pstate <= (data_in == HEADER_W) ? CHAN : HUNT;
        CHAN: begin
          if (data_in == HEADER_W) begin
`ifdef FRAME_TIMEOUT_EN
            r_tmo <= r_tmo + 1'b1;
`endif
          end else if (!is_chan_word(data_in) || !w_any_free) begin
            frame_drop <= 1'b1;
            r_pstate   <= HUNT;
          end else begin
            r_pbank              <= w_claim_bank;
            r_busy[w_claim_bank] <= 1'b1;
            r_ch                 <= data_in[7:0];
            r_cnt                <= '0;
            r_crc                <= '0;
            r_d1                 <= '0;
            r_d2                 <= '0;
            r_pstate             <= DATA;
          end
        end
        DATA: begin
          if (w_trailer) begin
            r_pstate <= HUNT;
            if (r_crc == r_d2) begin
              crc_valid        <= 1'b1;
              r_ready[r_pbank] <= 1'b1;
              if (!r_ready[~r_pbank]) r_older <= r_pbank;
              r_blen[r_pbank]  <= 3'(r_cnt - CNT_TRL);
              r_bch[r_pbank]   <= r_ch;
            end else begin
              crc_err          <= 1'b1;
              r_busy[r_pbank]  <= 1'b0;
            end
          end else if (w_overflow) begin
            frame_drop      <= 1'b1;
            r_busy[r_pbank] <= 1'b0;
            r_pstate        <= HUNT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_d1  <= data_in;
            r_d2  <= r_d1;
            if (r_cnt >= CNT_CRC) r_crc <= w_crc_next;
          end
        end
        default: r_pstate <= HUNT;
      endcase
    end
  end

  // Drain FSM feeding a one-entry output stage that holds while the FIFO is full.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_dstate <= D_IDLE;
      r_dbank  <= 1'b0;
      r_didx   <= '0;
      r_ov     <= 1'b0;
      r_od     <= '0;
    end else begin
      if (w_adv) r_ov <= 1'b0;
      case (r_dstate)
        D_IDLE: begin
          if (|r_ready) begin
            r_dbank  <= w_pick;
            r_didx   <= '0;
            r_dstate <= D_DESC;
          end
        end
        D_DESC: begin
          if (w_adv) begin
            r_ov     <= 1'b1;
            r_od     <= w_desc;
            r_dstate <= D_DATA;
          end
        end
        D_DATA: begin
          if (w_adv) begin
            r_ov   <= 1'b1;
            r_od   <= r_bank[r_dbank][r_didx];
            r_didx <= r_didx + 1'b1;
            if (w_last) r_dstate <= D_IDLE;
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  assign fifo_wr_en = r_ov & ~fifo_full;
  assign fifo_wdata = r_od;

endmodule
`default_nettype wire
